// File: rtl/wb4_bram.sv
// Wishbone B4 pipelined slave backed by a block RAM, with a small in-order command queue.
// Optional macro WB4BRAM_OOR_ERR_EN adds wb_err_o for word addresses >= DEPTH.
module wb4_bram #(
  parameter int unsigned ARCHBITSZ = 32,
  parameter int unsigned DEPTH     = 4096,
  parameter int unsigned QDEPTH    = 4,
  localparam int unsigned ADDRBITSZ = ARCHBITSZ - $clog2(ARCHBITSZ / 8)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     wb_cyc_i,
  input  logic                     wb_stb_i,
  input  logic                     wb_we_i,
  input  logic [ADDRBITSZ-1:0]     wb_addr_i,
  input  logic [ARCHBITSZ/8-1:0]   wb_sel_i,
  input  logic [ARCHBITSZ-1:0]     wb_dat_i,
  output logic                     wb_bsy_o,
  output logic                     wb_ack_o,
  output logic [ARCHBITSZ-1:0]     wb_dat_o
`ifdef WB4BRAM_OOR_ERR_EN
  ,
  output logic                     wb_err_o
`endif
);

  localparam int unsigned SELW = ARCHBITSZ / 8;
  localparam int unsigned PTRW = $clog2(QDEPTH);
  localparam int unsigned CNTW = PTRW + 1;
  localparam int unsigned IDXW = $clog2(DEPTH);

  // Command queue storage; control state lives in the reset block below.
  logic                 q_we   [QDEPTH];
  logic [ADDRBITSZ-1:0] q_addr [QDEPTH];
  logic [SELW-1:0]      q_sel  [QDEPTH];
  logic [ARCHBITSZ-1:0] q_dat  [QDEPTH];

  logic [ARCHBITSZ-1:0] mem [DEPTH];

  logic [PTRW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CNTW-1:0]      count_q;
  logic                 ack_q;
  logic [ARCHBITSZ-1:0] dat_q;

  logic                 push, pop, oor, exec_ok;
  logic                 h_we;
  logic [ADDRBITSZ-1:0] h_addr;
  logic [SELW-1:0]      h_sel;
  logic [ARCHBITSZ-1:0] h_dat;
  logic [IDXW-1:0]      h_idx;

  assign wb_bsy_o = (count_q == CNTW'(QDEPTH));
  assign push     = wb_cyc_i && wb_stb_i && !wb_bsy_o;
  assign pop      = wb_cyc_i && (count_q != '0);

  assign h_we   = q_we[rd_ptr_q];
  assign h_addr = q_addr[rd_ptr_q];
  assign h_sel  = q_sel[rd_ptr_q];
  assign h_dat  = q_dat[rd_ptr_q];
  assign h_idx  = h_addr[IDXW-1:0];

`ifdef WB4BRAM_OOR_ERR_EN
  localparam logic [ADDRBITSZ:0] DepthW = (ADDRBITSZ + 1)'(DEPTH);
  logic err_q;

  assign oor      = ({1'b0, h_addr} >= DepthW);
  assign wb_err_o = err_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      err_q <= 1'b0;
    end else begin
      err_q <= pop && oor;
    end
  end
`else
  // Upper address bits alias modulo DEPTH when the range check is absent.
  logic unused_addr;
  assign unused_addr = ^h_addr;
  assign oor         = 1'b0;
`endif

  assign exec_ok  = pop && !oor;
  assign wb_ack_o = ack_q;
  assign wb_dat_o = dat_q;

  always_ff @(posedge clk_i) begin
    if (push) begin
      q_we[wr_ptr_q]   <= wb_we_i;
      q_addr[wr_ptr_q] <= wb_addr_i;
      q_sel[wr_ptr_q]  <= wb_sel_i;
      q_dat[wr_ptr_q]  <= wb_dat_i;
    end
  end

  // RAM is deliberately outside the reset domain so contents survive rst_i.
  always_ff @(posedge clk_i) begin
    if (exec_ok && h_we) begin
      for (int b = 0; b < int'(SELW); b++) begin
        if (h_sel[b]) mem[h_idx][b*8 +: 8] <= h_dat[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ack_q    <= 1'b0;
      dat_q    <= '0;
    end else if (!wb_cyc_i) begin
      // Abort flushes everything still queued; executed writes stay in RAM.
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ack_q    <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTRW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTRW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNTW'(1);
        2'b01:   count_q <= count_q - CNTW'(1);
        default: count_q <= count_q;
      endcase
      ack_q <= exec_ok;
      if (exec_ok && !h_we) dat_q <= mem[h_idx];
    end
  end

endmodule
